// File: rtl/mem_pkg.sv
// Shared memory-map constants and requester encoding for the IF/MEM memory port.
package mem_pkg;

    localparam int AW         = 6;   // memory word-address width
    localparam int SEG_WORDS  = 32;  // words per segment (instruction and data)
    localparam int DATA_BASE  = 32;  // physical word offset of the data segment
    localparam int STARVE_MAX = 4;   // denied fetch cycles before fetch wins a conflict

    typedef enum logic [1:0] {REQ_NONE, REQ_IF, REQ_DM} req_t;

    // Segment-relative address check on the full 32-bit address, so large
    // values can never alias back into the array through truncation.
    function automatic logic in_seg(input logic [31:0] addr);
        return addr < 32'(SEG_WORDS);
    endfunction

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating count of consecutive cycles in which fetch was denied the memory.
module starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt_reg;

    // Clear wins over increment; the count stops at STARVE_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && !at_max) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign at_max = (cnt_reg == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported synchronous-read memory between instruction fetch
// (words 0..31) and data access (words 32..63). One grant per cycle, data has
// priority unless fetch has been starved; responses appear one cycle later.
module mem_arbiter
    import mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    // instruction fetch port
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    // data memory port
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [31:0]   dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [31:0]   dm_rdata,
    output logic          dm_err,
    // memory array port
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    logic          starve_max;
    logic          if_in;
    logic          dm_in;
    logic [AW-1:0] dm_phys;
    logic          rdata_ok;

    req_t resp_who_reg, resp_who_next;
    logic resp_we_reg,  resp_we_next;
    logic resp_err_reg, resp_err_next;

    starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (if_req & ~if_gnt),
        .clr    (~if_req | if_gnt),
        .at_max (starve_max)
    );

    assign if_in = in_seg(if_addr);
    assign dm_in = in_seg(dm_addr);
    // Only the low AW bits survive into the physical address, so add there.
    assign dm_phys = dm_addr[AW-1:0] + AW'(DATA_BASE);

    // Grant: data first unless fetch has waited STARVE_MAX cycles; nothing in reset.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (rst_n) begin
            if_gnt = if_req && (!dm_req || starve_max);
            dm_gnt = dm_req && !if_gnt;
        end
    end

    // Memory strobes for the granted access and the response it will produce.
    always_comb begin
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        resp_who_next = REQ_NONE;
        resp_we_next  = 1'b0;
        resp_err_next = 1'b0;
        if (if_gnt) begin
            mem_en        = if_in;
            mem_addr      = if_addr[AW-1:0];
            resp_who_next = REQ_IF;
            resp_err_next = !if_in;
        end else if (dm_gnt) begin
            mem_en        = dm_in;
            mem_we        = dm_in && dm_we;
            mem_addr      = dm_phys;
            mem_wdata     = dm_wdata;
            resp_who_next = REQ_DM;
            resp_we_next  = dm_we;
            resp_err_next = !dm_in;
        end
    end

    // Response register: one-cycle record of who was granted and how.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_who_reg <= REQ_NONE;
            resp_we_reg  <= 1'b0;
            resp_err_reg <= 1'b0;
        end else begin
            resp_who_reg <= resp_who_next;
            resp_we_reg  <= resp_we_next;
            resp_err_reg <= resp_err_next;
        end
    end

    // Writes and out-of-range accesses return zero instead of array data.
    assign rdata_ok  = !resp_we_reg && !resp_err_reg;
    assign if_rvalid = (resp_who_reg == REQ_IF);
    assign dm_rvalid = (resp_who_reg == REQ_DM);
    assign if_rdata  = (if_rvalid && rdata_ok) ? mem_rdata : '0;
    assign dm_rdata  = (dm_rvalid && rdata_ok) ? mem_rdata : '0;
    assign dm_err    = dm_rvalid && resp_err_reg;

endmodule
